// File: rtl/wisc_mem_pkg.sv
// Shared types and default widths for the WISC memory-access stage and its neighbours.
package wisc_mem_pkg;

   localparam int unsigned DATA_W_DEF   = 16;
   localparam int unsigned REG_AW_DEF   = 3;
   localparam int unsigned MAX_WAIT_DEF = 15;

   // MEM/WB bundle field widths, shared with the EX and WB stages
   localparam int unsigned WB_CTRL_W = 3;  // halt, mem_to_reg, reg_write

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2
   } mem_state_e;

endpackage

// File: rtl/wisc_mem_wb_reg.sv
// MEM/WB pipeline register: loads the completing slot, inserts a bubble otherwise.
module wisc_mem_wb_reg
   import wisc_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              rdata_load_i,
   input  logic              halt_i,
   input  logic              mem_to_reg_i,
   input  logic              reg_write_i,
   input  logic [REG_AW-1:0] write_reg_i,
   input  logic [DATA_W-1:0] read_data_i,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              valid_o,
   output logic              halt_o,
   output logic              mem_to_reg_o,
   output logic              reg_write_o,
   output logic [REG_AW-1:0] write_reg_o,
   output logic [DATA_W-1:0] read_data_o,
   output logic [DATA_W-1:0] alu_result_o
);

   logic              valid_q, halt_q, mem_to_reg_q, reg_write_q;
   logic [REG_AW-1:0] write_reg_q;
   logic [DATA_W-1:0] read_data_q, alu_result_q;

   // Valid and reg_write clear on any non-loading cycle; payload holds until the next load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         halt_q       <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         read_data_q  <= '0;
         alu_result_q <= '0;
      end else begin
         valid_q     <= load_i;
         reg_write_q <= load_i & reg_write_i;
         if (load_i) begin
            halt_q       <= halt_i;
            mem_to_reg_q <= mem_to_reg_i;
            write_reg_q  <= write_reg_i;
            alu_result_q <= alu_result_i;
            if (rdata_load_i) read_data_q <= read_data_i;
         end
      end
   end

   assign valid_o      = valid_q;
   assign halt_o       = halt_q;
   assign mem_to_reg_o = mem_to_reg_q;
   assign reg_write_o  = reg_write_q;
   assign write_reg_o  = write_reg_q;
   assign read_data_o  = read_data_q;
   assign alu_result_o = alu_result_q;

endmodule

// File: rtl/wisc_mem.sv
// WISC memory-access stage: drives the variable-latency data memory, stalls upstream
// while an access is outstanding, flags unaligned/conflicting/timed-out accesses and
// parks after HALT.
module wisc_mem
   import wisc_mem_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned REG_AW   = REG_AW_DEF,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_mem_to_reg,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_write_reg,
   input  logic              ex_halt,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   output logic              dm_req,
   output logic              dm_wr,
   output logic [DATA_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_done,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic              wb_halt,
   output logic              wb_mem_to_reg,
   output logic              wb_reg_write,
   output logic [REG_AW-1:0] wb_write_reg,
   output logic [DATA_W-1:0] wb_read_data,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic             mem_op, bad, complete;

   assign dm_addr  = ex_alu_result;
   assign dm_wdata = ex_store_data;
   assign err      = err_q;

   // Next-state, wait counter, error and memory/stall outputs
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      dm_req     = 1'b0;
      dm_wr      = 1'b0;
      mem_stall  = 1'b0;
      complete   = 1'b0;
      mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
      bad        = mem_op & (ex_alu_result[0] | (ex_mem_read & ex_mem_write));
      case (state_q)
         ST_IDLE: begin
            mem_stall = mem_op & ~dm_done & ~bad;
            if (bad) begin
               err_d   = 1'b1;
               state_d = ST_HALTED;
            end else if (mem_op) begin
               dm_req = 1'b1;
               dm_wr  = ex_mem_write;
               if (dm_done) begin
                  complete = 1'b1;
               end else begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = CNT_W'(1);
               end
            end else if (ex_valid) begin
               complete = 1'b1;
            end
         end
         ST_WAIT: begin
            dm_req    = 1'b1;
            dm_wr     = ex_mem_write;
            mem_stall = mem_op & ~dm_done & ~bad;
            if (dm_done) begin
               complete   = 1'b1;
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
               err_d      = 1'b1;
               state_d    = ST_HALTED;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_HALTED: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A completing HALT overrides the IDLE return so the stage parks after it
      if (complete && ex_halt) state_d = ST_HALTED;
   end

   // State, wait counter and sticky error registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   wisc_mem_wb_reg #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_mem_wb (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (complete),
      .rdata_load_i (ex_mem_read),
      .halt_i       (ex_halt),
      .mem_to_reg_i (ex_mem_to_reg),
      .reg_write_i  (ex_reg_write),
      .write_reg_i  (ex_write_reg),
      .read_data_i  (dm_rdata),
      .alu_result_i (ex_alu_result),
      .valid_o      (wb_valid),
      .halt_o       (wb_halt),
      .mem_to_reg_o (wb_mem_to_reg),
      .reg_write_o  (wb_reg_write),
      .write_reg_o  (wb_write_reg),
      .read_data_o  (wb_read_data),
      .alu_result_o (wb_alu_result)
   );

endmodule

// File: tb/tb_wisc_mem.sv
// Scoreboard bench for wisc_mem: stimulus pushes expected MEM/WB slots, a negedge
// monitor pops and compares whenever wb_valid is seen.
module tb_wisc_mem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_halt;
   logic [2:0]  ex_write_reg;
   logic [15:0] ex_alu_result, ex_store_data;
   logic        dm_req, dm_wr, dm_done;
   logic [15:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_stall, wb_valid, wb_halt, wb_mem_to_reg, wb_reg_write, err;
   logic [2:0]  wb_write_reg;
   logic [15:0] wb_read_data, wb_alu_result;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        halt;
      logic        m2r;
      logic        rw;
      logic [2:0]  wreg;
      logic        chk_rd;
      logic [15:0] rd;
      logic [15:0] alu;
   } exp_t;
   exp_t sb[$];

   wisc_mem #(.DATA_W(16), .REG_AW(3), .MAX_WAIT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .ex_write_reg(ex_write_reg), .ex_halt(ex_halt),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
      .wb_valid(wb_valid), .wb_halt(wb_halt), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
      .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_ex(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [2:0] wreg, input logic halt,
                         input logic [15:0] addr, input logic [15:0] sdata);
      ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = m2r;
      ex_reg_write = rw; ex_write_reg = wreg; ex_halt = halt;
      ex_alu_result = addr; ex_store_data = sdata;
   endtask

   task automatic nop();
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
      dm_done = 1'b0;
      dm_rdata = 16'h0000;
   endtask

   task automatic push_exp(input logic halt, input logic m2r, input logic rw,
                           input logic [2:0] wreg, input logic chk_rd,
                           input logic [15:0] rd, input logic [15:0] alu);
      exp_t e;
      e.halt = halt; e.m2r = m2r; e.rw = rw; e.wreg = wreg;
      e.chk_rd = chk_rd; e.rd = rd; e.alu = alu;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0; nop();
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   // Monitor: every wb_valid pulse must match the oldest expected slot
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_unexpected: got wb_valid=1 expected no slot at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_halt", wb_halt, e.halt);
            chk("wb_mem_to_reg", wb_mem_to_reg, e.m2r);
            chk("wb_reg_write", wb_reg_write, e.rw);
            chk("wb_write_reg", wb_write_reg, e.wreg);
            chk("wb_alu_result", wb_alu_result, e.alu);
            if (e.chk_rd) chk("wb_read_data", wb_read_data, e.rd);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with a pending load presented
      rst_n = 1'b0;
      nop();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 16'h0010, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_halt", wb_halt, 0);
      chk("rst_wb_m2r", wb_mem_to_reg, 0);
      chk("rst_wb_rw", wb_reg_write, 0);
      chk("rst_wb_wreg", wb_write_reg, 0);
      chk("rst_wb_rd", wb_read_data, 0);
      chk("rst_wb_alu", wb_alu_result, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1 rst_n = 1'b1; nop();
      @(negedge clk);
      chk("rst_dm_req", dm_req, 0);
      chk("rst_stall", mem_stall, 0);

      // Zero-wait load
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 16'h0010, 16'h0000);
      dm_done = 1'b1; dm_rdata = 16'hBEEF;
      push_exp(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 16'hBEEF, 16'h0010);
      @(negedge clk);
      chk("zw_req", dm_req, 1);
      chk("zw_wr", dm_wr, 0);
      chk("zw_addr", dm_addr, 16'h0010);
      chk("zw_stall", mem_stall, 0);
      @(posedge clk); #1 nop();
      @(negedge clk);
      chk("zw_stall_after", mem_stall, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zw_bubble", wb_valid, 0);

      // Store with three wait cycles, done on the fourth
      @(posedge clk); #1;
      set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 16'h0020, 16'h1234);
      push_exp(1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 16'h0000, 16'h0020);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         chk("st_stall", mem_stall, 1);
         chk("st_req", dm_req, 1);
         chk("st_wr", dm_wr, 1);
         chk("st_addr", dm_addr, 16'h0020);
         chk("st_wdata", dm_wdata, 16'h1234);
         chk("st_no_wb", wb_valid, 0);
      end
      @(posedge clk); #1 dm_done = 1'b1;
      @(negedge clk);
      chk("st_done_stall", mem_stall, 0);
      chk("st_done_req", dm_req, 1);
      @(posedge clk); #1 nop();
      @(negedge clk);
      chk("st_idle_req", dm_req, 0);

      // ADD followed by HALT
      @(posedge clk); #1;
      set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 16'h0007, 16'h0000);
      push_exp(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 16'h0000, 16'h0007);
      @(negedge clk);
      chk("add_stall", mem_stall, 0);
      chk("add_req", dm_req, 0);
      @(posedge clk); #1;
      set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h0000, 16'h0000);
      push_exp(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      chk("halt_stall", mem_stall, 0);
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0050, 16'h0000);
      @(negedge clk);
      chk("halted_stall", mem_stall, 1);
      chk("halted_req", dm_req, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("halted_wb_valid", wb_valid, 0);
         chk("halted_stall_hold", mem_stall, 1);
      end
      do_reset();

      // Unaligned load
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 16'h0021, 16'h0000);
      @(negedge clk);
      chk("ua_req", dm_req, 0);
      chk("ua_stall", mem_stall, 0);
      chk("ua_err_pre", err, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ua_err", err, 1);
      chk("ua_stall_halted", mem_stall, 1);
      chk("ua_wb_valid", wb_valid, 0);
      chk("ua_req_halted", dm_req, 0);
      do_reset();
      @(negedge clk);
      chk("ua_err_cleared", err, 0);

      // Read and write together on an aligned address
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0022, 16'h00AA);
      @(negedge clk);
      chk("rw_req", dm_req, 0);
      @(posedge clk); #1 nop();
      @(negedge clk);
      chk("rw_err", err, 1);
      chk("rw_stall", mem_stall, 1);
      do_reset();

      // Timeout: dm_done never arrives
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 16'h0030, 16'h0000);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         chk("to_req", dm_req, 1);
         if (c == 15) chk("to_err_pre", err, 0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_err", err, 1);
      chk("to_req_drop", dm_req, 0);
      chk("to_stall", mem_stall, 1);
      do_reset();

      // Reset in the middle of a WAIT abandons the access
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 16'h0040, 16'h0000);
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("mw_req", dm_req, 1);
      @(posedge clk); #1 rst_n = 1'b0; nop();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mw_req_drop", dm_req, 0);
      chk("mw_stall", mem_stall, 0);
      chk("mw_err", err, 0);

      // Back-to-back operation after reset
      @(posedge clk); #1;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0044, 16'h0000);
      dm_done = 1'b1; dm_rdata = 16'h5A5A;
      push_exp(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 16'h5A5A, 16'h0044);
      @(posedge clk); #1 nop();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
